// File: rtl/mem_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_deserializer_pkg
//  Description : Constants shared by the config-memory serializer and
//                deserializer: frame geometry defaults, slave address,
//                inter-byte timeout default and the SYNC/COLLECT encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_deserializer_pkg;

    localparam int unsigned C_MEM_WIDTH      = 24;
    localparam int unsigned C_DATA_WIDTH     = 8;
    localparam int unsigned C_WORD_NUMBER    = 326;
    localparam logic [7:0]  C_SLAVE_ADDR     = 8'hE8;
    localparam int unsigned C_TIMEOUT_CYCLES = 1_000_000;

    // Frame tracking: waiting for a header byte, or inside a frame.
    typedef enum logic [0:0] {
        ST_SYNC    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mem_deserializer_pkg
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_counter
//  Description : Idle-cycle counter with synchronous clear and enable.
//                tc_o is a single-cycle combinational terminal-count flag
//                raised on the cycle the count sits at TIMEOUT_CYCLES-1 while
//                enabled; the count restarts from zero on that edge.
//                TIMEOUT_CYCLES = 0 disables tc_o entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module timeout_counter
    import mem_deserializer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned    CNT_W    = width_min1(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic           ENABLED  = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc_o = ENABLED && enable_i && !clear_i && (count_q == TERMINAL);

    // Next count: clear wins, otherwise count up and restart after terminal.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == TERMINAL) ? '0 : count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : timeout_counter
`default_nettype wire

// File: rtl/mem_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_deserializer
//  Description : Receives a byte stream framed as one slave-address byte
//                followed by WORD_NUMBER groups of {addr_hi, addr_lo, data},
//                reassembles each group into a MEM_WIDTH word and writes it to
//                the readback RAM. A frame stalled for TIMEOUT_CYCLES clocks
//                between bytes is abandoned and the receiver resynchronises.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_deserializer
    import mem_deserializer_pkg::*;
#(
    parameter int unsigned            MEM_WIDTH      = C_MEM_WIDTH,
    parameter int unsigned            DATA_WIDTH     = C_DATA_WIDTH,
    parameter int unsigned            WORD_NUMBER    = C_WORD_NUMBER,
    parameter logic [DATA_WIDTH-1:0]  SLAVE_ADDR     = DATA_WIDTH'(C_SLAVE_ADDR),
    parameter int unsigned            TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           valid_i,
    input  logic [DATA_WIDTH-1:0]          data_i,
    output logic                           ack_o,
    output logic                           wr_en_o,
    output logic [$clog2(WORD_NUMBER)-1:0] wr_index_o,
    output logic [MEM_WIDTH-1:0]           wr_data_o,
    output logic                           done_o,
    output logic                           addr_err_o,
    output logic                           timeout_o,
    output logic                           busy_o
);

    localparam int unsigned      IDX_W     = $clog2(WORD_NUMBER);
    localparam int unsigned      BPW       = MEM_WIDTH / DATA_WIDTH;
    localparam int unsigned      BC_W      = width_min1(BPW);
    localparam logic [BC_W-1:0]  BC_RELOAD = BC_W'(BPW - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_NUMBER - 1);

    state_t               state_q,    state_d;
    logic                 ack_q,      ack_d;
    logic                 wr_en_q,    wr_en_d;
    logic                 done_q,     done_d;
    logic                 addr_err_q, addr_err_d;
    logic                 timeout_q,  timeout_d;
    logic [IDX_W-1:0]     wr_index_q, wr_index_d;
    logic [MEM_WIDTH-1:0] wr_data_q,  wr_data_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [BC_W-1:0]      bcnt_q,     bcnt_d;
    logic [MEM_WIDTH-1:0] shreg_q,    shreg_d;

    logic                 accept;
    logic                 in_collect;
    logic                 tmo_tc;
    logic [MEM_WIDTH-1:0] shreg_shifted;

    // A byte is taken only when not already acknowledging the previous one,
    // which forces at least two clocks between consecutive bytes.
    assign accept        = valid_i && !ack_q;
    assign in_collect    = (state_q == ST_COLLECT);
    assign shreg_shifted = {shreg_q[MEM_WIDTH-DATA_WIDTH-1:0], data_i};

    // Inter-byte idle counter; only runs inside a frame.
    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .clear_i  (!in_collect || accept),
        .enable_i (in_collect),
        .tc_o     (tmo_tc)
    );

    // Frame FSM next-state, word assembly and registered output pulses.
    always_comb begin
        state_d    = state_q;
        ack_d      = accept;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        addr_err_d = 1'b0;
        timeout_d  = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;

        case (state_q)
            ST_SYNC: begin
                if (accept) begin
                    if (data_i == SLAVE_ADDR) begin
                        state_d = ST_COLLECT;
                        bcnt_d  = BC_RELOAD;
                        shreg_d = '0;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (accept) begin
                    // A byte on the terminal-count edge wins over the timeout.
                    shreg_d = shreg_shifted;
                    if (bcnt_q == '0) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = shreg_shifted;
                        wr_index_d = idx_q;
                        bcnt_d     = BC_RELOAD;
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            idx_d   = '0;
                            state_d = ST_SYNC;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q - BC_W'(1);
                    end
                end else if (tmo_tc) begin
                    // Abandon the frame: drop the partial word, restart indexing.
                    timeout_d = 1'b1;
                    shreg_d   = '0;
                    bcnt_d    = BC_RELOAD;
                    idx_d     = '0;
                    state_d   = ST_SYNC;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_SYNC;
            ack_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
            idx_q      <= '0;
            bcnt_q     <= BC_RELOAD;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            timeout_q  <= timeout_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
        end
    end

    assign ack_o      = ack_q;
    assign wr_en_o    = wr_en_q;
    assign wr_index_o = wr_index_q;
    assign wr_data_o  = wr_data_q;
    assign done_o     = done_q;
    assign addr_err_o = addr_err_q;
    assign timeout_o  = timeout_q;
    assign busy_o     = in_collect;

endmodule : mem_deserializer
`default_nettype wire

// File: doc/mem_deserializer.md
Name: mem_deserializer

Overview:
- Receive-side counterpart of the config-memory byte serializer.
- Accepts a byte stream framed as one slave-address byte followed by WORD_NUMBER groups of {addr_hi, addr_lo, data}.
- Reassembles each group into a MEM_WIDTH word and writes it into a config/readback RAM through a simple write port.
- Sits between the I2C byte-level receiver (or loopback of the serializer in sim) and the readback memory used for configuration compare.

Parameters:
- MEM_WIDTH, 24: assembled word width; [23:8] register address, [7:0] data.
- DATA_WIDTH, 8: byte width on the input.
- WORD_NUMBER, 326: words per frame.
- SLAVE_ADDR, 8'hE8: expected first byte of a frame, i.e. 7-bit address 1110100 plus write bit 0.
- TIMEOUT_CYCLES, 1_000_000: max idle clocks between bytes inside a frame; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- valid_i  in  1  data_i holds a new byte.
- data_i  in  DATA_WIDTH  incoming byte.
- ack_o  out  1  one-cycle pulse: byte accepted.
- wr_en_o  out  1  one-cycle RAM write strobe.
- wr_index_o  out  $clog2(WORD_NUMBER)  RAM word index.
- wr_data_o  out  MEM_WIDTH  assembled word.
- done_o  out  1  one-cycle pulse: last word of the frame written.
- addr_err_o  out  1  one-cycle pulse: header byte != SLAVE_ADDR.
- timeout_o  out  1  one-cycle pulse: frame aborted on inter-byte timeout.
- busy_o  out  1  high while inside a frame (state COLLECT).

Behaviour:
- Reset (async, arst_i=1): all outputs 0; state SYNC; byte counter = MEM_WIDTH/DATA_WIDTH-1; word index 0; shift register 0; timeout counter 0.
- Reset asserted mid-frame drops the partial word. No wr_en_o is issued during or after reset release.
- Accept condition at a rising edge: valid_i=1 AND ack_o=0. valid_i is ignored during the ack_o cycle, which spaces bytes at a minimum of 2 clocks.
- Every accepted byte produces ack_o=1 for exactly the next cycle, including rejected header bytes.
- State SYNC:
  - Accepted byte == SLAVE_ADDR: go to COLLECT.
  - Otherwise: addr_err_o pulses with ack_o; remain in SYNC.
  - No timeout counting in SYNC.
- State COLLECT:
  - Each accepted byte shifts in MSB-first: shreg <= {shreg[MEM_WIDTH-DATA_WIDTH-1:0], data_i}.
  - When the 3rd byte of a group is accepted at edge k, the cycle after edge k carries:
    - ack_o=1, wr_en_o=1
    - wr_data_o = assembled word, including that 3rd byte
    - wr_index_o = current index
    - byte counter reloads.
  - Index increments on the same edge; wr_index_o holds the value written.
  - If index == WORD_NUMBER-1: done_o=1 in the same cycle as the last wr_en_o; index wraps to 0; state SYNC.
- Timeout (COLLECT only):
  - Counter clears on every accepted byte and increments otherwise.
  - At TIMEOUT_CYCLES-1: timeout_o pulses; partial word discarded; index reset to 0; state SYNC; no write.
- Simultaneous events:
  - A byte accepted on the edge the timeout would fire wins; the counter clears and there is no timeout.
  - wr_en_o and done_o can coincide; done_o never fires without wr_en_o.
- wr_data_o and wr_index_o hold their last values between strobes.

Decomposition:
- Shared constants file: SLAVE_ADDR, MEM_WIDTH, DATA_WIDTH, WORD_NUMBER defaults and SYNC/COLLECT state encoding, common to serializer and deserializer.
- One natural sub-module: timeout_counter (clear, enable, terminal-count pulse, width $clog2(TIMEOUT_CYCLES)), reusable for the serializer pause.

Test Plan:
- Reset then bytes E8,00,0B,24 with valid 1-cycle pulses, gap 3 clocks -> four ack_o pulses; one wr_en_o with wr_index_o=0, wr_data_o=24'h000B24; busy_o=1 after E8.
- Full frame, WORD_NUMBER=4: E8 then 12 bytes -> wr_en_o at indices 0..3; done_o coincident with index 3; busy_o=0 after; next E8 restarts at index 0.
- Header byte 8'hE9 -> ack_o and addr_err_o pulse; no wr_en_o on following bytes until E8 is seen.
- TIMEOUT_CYCLES=16: E8,01,02 then silence -> timeout_o exactly 16 clocks after the last ack_o edge; no write; following E8,AA,BB,CC writes 24'hAABBCC at index 0.
- valid_i held high continuously for 6 clocks after E8 -> exactly 3 bytes accepted (alternate cycles), wr_en_o once.
- arst_i pulsed after 2 data bytes -> all outputs 0 immediately; fresh E8 plus 3 bytes writes index 0 with only the new bytes.
